mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external memory port between the instruction cache (client 0) and the data cache (client 1).
- Grants one client at a time and holds the grant for exactly one memory transaction.
- Passes the owner's request, write data and read response through unchanged; the other client is stalled.
- Sits between both cache instances and the memory model/DRAM interface at the top level.

Parameters:
- ADDR_BITS, 28, mem word address width (CPU_ADDR_BITS-2 minus log2 of MEM_DATA_BITS/32).
- DATA_BITS, 128, `MEM_DATA_BITS.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority to client 1 (dcache).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cli_req_valid  in  2  per-client request valid, bit i = client i.
- cli_req_ready  out  2  per-client request accepted.
- cli_req_addr  in  2*ADDR_BITS  packed addresses; client i at [i*ADDR_BITS +: ADDR_BITS].
- cli_req_rw  in  2  1 = write, 0 = read.
- cli_req_data_valid  in  2  write data valid.
- cli_req_data_ready  out  2  write data accepted.
- cli_req_data_bits  in  2*DATA_BITS  packed write data.
- cli_req_data_mask  in  2*(DATA_BITS/8)  packed byte masks.
- cli_resp_valid  out  2  read response valid, owner only.
- cli_resp_data  out  DATA_BITS  shared response data bus.
- mem_req_valid  out  1  to memory.
- mem_req_ready  in  1  from memory.
- mem_req_addr  out  ADDR_BITS  to memory.
- mem_req_rw  out  1  to memory.
- mem_req_data_valid  out  1  to memory.
- mem_req_data_ready  in  1  from memory.
- mem_req_data_bits  out  DATA_BITS  to memory.
- mem_req_data_mask  out  DATA_BITS/8  to memory.
- mem_resp_valid  in  1  from memory.
- mem_resp_data  in  DATA_BITS  from memory.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Registered state: IDLE, REQ, RESP, plus owner (1 bit), rr_last (1 bit), req_done and data_done flags.
- Reset (reset low, asynchronous): state=IDLE, owner=0, rr_last=1 (so client 0 wins the first tie), both flags=0.
- All valid/ready outputs are 0 in IDLE and during reset. mem_req_addr/data/mask/rw carry don't-care values but must never be X-propagated into a valid.
- IDLE:
  - No request: stay in IDLE.
  - Any cli_req_valid: pick the winner and register it as owner.
  - PRIO_MODE=0: with both requesting, pick !rr_last. PRIO_MODE=1: client 1 wins ties.
  - Go to REQ. Arbitration costs one cycle; no ready is asserted in IDLE.
- REQ:
  - Drive mem_req_valid/addr/rw from the owner; cli_req_ready[owner] = mem_req_ready. Non-owner ready = 0.
  - Write (owner rw=1): also pass through mem_req_data_valid/bits/mask; cli_req_data_ready[owner] = mem_req_data_ready.
  - Write handshakes may complete in either order or the same cycle; each sets its done flag. Once a flag is set, the corresponding mem valid is forced low.
  - Write completes when both flags are set (including same-cycle completion). Then go to IDLE, update rr_last=owner, clear the flags.
  - Read: after the req handshake, go to RESP.
- RESP:
  - cli_resp_valid[owner] = mem_resp_valid; cli_resp_data = mem_resp_data.
  - On mem_resp_valid: go to IDLE, rr_last=owner.
  - mem_resp_valid in any other state is ignored: no cli_resp_valid is raised.
- Grant is never pre-empted mid-transaction. The non-owner's valid is held off without being dropped; the arbiter does not require it to stay asserted.
- If the owner drops cli_req_valid in REQ before handshake, the arbiter returns to IDLE next cycle without re-arbitrating, and rr_last is unchanged.
- Refill sequences (4 consecutive reads) are arbitrated per read. With both clients active under PRIO_MODE=0, reads alternate.
- Reset asserted mid-transaction aborts immediately. The memory side is expected to be reset by the same signal.
- busy is high whenever state is not IDLE.

Test Plan:
- Single read, client 0 addr 0x0000010, mem_req_ready=1, resp 3 cycles later with data 0xA5..A5 -> mem_req_valid high on cycle 1 after request, cli_resp_valid=2'b01 for one cycle with 0xA5..A5, busy back to 0.
- Both clients issue reads simultaneously, PRIO_MODE=0, after reset -> client 0 served first, then client 1. Repeat -> order alternates. PRIO_MODE=1 -> client 1 always first.
- Client 1 write, mask 16'h000F, mem_req_ready asserted 2 cycles before mem_req_data_ready -> each handshake seen exactly once, mem_req_valid drops after accept, return to IDLE after data handshake, no cli_resp_valid.
- Write with both readies high on the same cycle -> single-cycle REQ, both cli readies pulse together, IDLE next cycle.
- Spurious mem_resp_valid in IDLE -> cli_resp_valid stays 2'b00. Client 0 drops valid in REQ -> IDLE, client 1 then granted.
- reset pulled low during RESP -> all outputs 0 asynchronously. After release, a new read from client 1 completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between icache (client 0) and dcache (client 1), one transaction per grant.
// Latency: one arbitration cycle in IDLE; afterwards request, write data and response pass through combinationally.
// Backpressure: the owner sees mem readies directly; the non-owner sees ready=0 and is held off until the grant frees.
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int PRIO_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 cli_req_valid,
    output logic [1:0]                 cli_req_ready,
    input  logic [2*ADDR_BITS-1:0]     cli_req_addr,
    input  logic [1:0]                 cli_req_rw,
    input  logic [1:0]                 cli_req_data_valid,
    output logic [1:0]                 cli_req_data_ready,
    input  logic [2*DATA_BITS-1:0]     cli_req_data_bits,
    input  logic [2*(DATA_BITS/8)-1:0] cli_req_data_mask,
    output logic [1:0]                 cli_resp_valid,
    output logic [DATA_BITS-1:0]       cli_resp_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_BITS-1:0]       mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [DATA_BITS-1:0]       mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]     mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [DATA_BITS-1:0]       mem_resp_data,
    output logic                       busy
);

    localparam int MASK_BITS = DATA_BITS / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state, state_d;
    logic   owner, owner_d;
    logic   rr_last, rr_last_d;
    logic   req_done, req_done_d;
    logic   data_done, data_done_d;

    logic   own_req_valid;
    logic   own_rw;
    logic   own_data_valid;
    logic   req_hs;
    logic   data_hs;
    logic   winner;

    assign own_req_valid  = cli_req_valid[owner];
    assign own_rw         = cli_req_rw[owner];
    assign own_data_valid = cli_req_data_valid[owner];
    assign req_hs         = mem_req_valid & mem_req_ready;
    assign data_hs        = mem_req_data_valid & mem_req_data_ready;
    assign busy           = (state != IDLE);

    // Winner selection: ties go to the client not served last, or always to dcache in priority mode.
    always_comb begin
        winner = cli_req_valid[1];
        if (cli_req_valid == 2'b11)
            winner = (PRIO_MODE != 0) ? 1'b1 : ~rr_last;
    end

    // Datapath and handshake routing; only the owner's valids/readies are ever connected.
    always_comb begin
        cli_req_ready      = 2'b00;
        cli_req_data_ready = 2'b00;
        cli_resp_valid     = 2'b00;
        cli_resp_data      = mem_resp_data;
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_rw         = own_rw;
        mem_req_addr       = owner ? cli_req_addr[ADDR_BITS +: ADDR_BITS]
                                   : cli_req_addr[0 +: ADDR_BITS];
        mem_req_data_bits  = owner ? cli_req_data_bits[DATA_BITS +: DATA_BITS]
                                   : cli_req_data_bits[0 +: DATA_BITS];
        mem_req_data_mask  = owner ? cli_req_data_mask[MASK_BITS +: MASK_BITS]
                                   : cli_req_data_mask[0 +: MASK_BITS];
        case (state)
            REQ: begin
                // A completed handshake is masked so neither side sees it twice.
                mem_req_valid             = own_req_valid & ~req_done;
                mem_req_data_valid        = own_rw & own_data_valid & ~data_done;
                cli_req_ready[owner]      = mem_req_ready & ~req_done;
                cli_req_data_ready[owner] = own_rw & mem_req_data_ready & ~data_done;
            end
            RESP: begin
                cli_resp_valid[owner] = mem_resp_valid;
            end
            default: ;
        endcase
    end

    // Next-state logic for the grant FSM and its bookkeeping registers.
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        rr_last_d   = rr_last;
        req_done_d  = req_done;
        data_done_d = data_done;
        case (state)
            IDLE: begin
                if (|cli_req_valid) begin
                    owner_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!req_done && !own_req_valid) begin
                    // Owner withdrew before acceptance: release without crediting the round-robin.
                    state_d     = IDLE;
                    req_done_d  = 1'b0;
                    data_done_d = 1'b0;
                end else if (!own_rw) begin
                    if (req_hs)
                        state_d = RESP;
                end else if ((req_done | req_hs) && (data_done | data_hs)) begin
                    state_d     = IDLE;
                    rr_last_d   = owner;
                    req_done_d  = 1'b0;
                    data_done_d = 1'b0;
                end else begin
                    req_done_d  = req_done | req_hs;
                    data_done_d = data_done | data_hs;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d   = IDLE;
                    rr_last_d = owner;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; rr_last resets to 1 so client 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            req_done  <= 1'b0;
            data_done <= 1'b0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            rr_last   <= rr_last_d;
            req_done  <= req_done_d;
            data_done <= data_done_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed check of mem_arbiter, round-robin instance plus a fixed-priority twin on shared stimulus.
// Latency: inputs driven at negedge, outputs sampled 1ns later.
// Backpressure: memory readies are driven directly per step.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic            clk;
    logic            reset;
    logic [1:0]      cli_req_valid;
    logic [2*AW-1:0] cli_req_addr;
    logic [1:0]      cli_req_rw;
    logic [1:0]      cli_req_data_valid;
    logic [2*DW-1:0] cli_req_data_bits;
    logic [2*MW-1:0] cli_req_data_mask;
    logic            mem_req_ready;
    logic            mem_req_data_ready;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_resp_data;

    logic [1:0]    r0_req_ready, r0_data_ready, r0_resp_valid;
    logic [DW-1:0] r0_resp_data, r0_data_bits;
    logic          r0_valid, r0_rw, r0_data_valid, r0_busy;
    logic [AW-1:0] r0_addr;
    logic [MW-1:0] r0_mask;

    logic [1:0]    p1_req_ready, p1_data_ready, p1_resp_valid;
    logic [DW-1:0] p1_resp_data, p1_data_bits;
    logic          p1_valid, p1_rw, p1_data_valid, p1_busy;
    logic [AW-1:0] p1_addr;
    logic [MW-1:0] p1_mask;

    int vectors    = 0;
    int miscompares = 0;

    mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .PRIO_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .cli_req_valid(cli_req_valid), .cli_req_ready(r0_req_ready),
        .cli_req_addr(cli_req_addr), .cli_req_rw(cli_req_rw),
        .cli_req_data_valid(cli_req_data_valid), .cli_req_data_ready(r0_data_ready),
        .cli_req_data_bits(cli_req_data_bits), .cli_req_data_mask(cli_req_data_mask),
        .cli_resp_valid(r0_resp_valid), .cli_resp_data(r0_resp_data),
        .mem_req_valid(r0_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(r0_addr), .mem_req_rw(r0_rw),
        .mem_req_data_valid(r0_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(r0_data_bits), .mem_req_data_mask(r0_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(r0_busy)
    );

    mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .PRIO_MODE(1)) dut_prio (
        .clk(clk), .reset(reset),
        .cli_req_valid(cli_req_valid), .cli_req_ready(p1_req_ready),
        .cli_req_addr(cli_req_addr), .cli_req_rw(cli_req_rw),
        .cli_req_data_valid(cli_req_data_valid), .cli_req_data_ready(p1_data_ready),
        .cli_req_data_bits(cli_req_data_bits), .cli_req_data_mask(cli_req_data_mask),
        .cli_resp_valid(p1_resp_valid), .cli_resp_data(p1_resp_data),
        .mem_req_valid(p1_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(p1_addr), .mem_req_rw(p1_rw),
        .mem_req_data_valid(p1_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(p1_data_bits), .mem_req_data_mask(p1_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(p1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset              = 1'b0;
        cli_req_valid      = 2'b00;
        cli_req_addr       = '0;
        cli_req_rw         = 2'b00;
        cli_req_data_valid = 2'b00;
        cli_req_data_bits  = '0;
        cli_req_data_mask  = '0;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_data      = '0;

        // Reset state
        #2;
        chk("rst_busy", r0_busy, 0);
        chk("rst_mem_valid", r0_valid, 0);
        chk("rst_ready", r0_req_ready, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single read from client 0, response three cycles after the request
        @(negedge clk);
        cli_req_valid = 2'b01;
        cli_req_addr[0 +: AW] = 28'h0000010;
        mem_req_ready = 1'b1;
        #1;
        chk("rd_idle_valid", r0_valid, 0);
        chk("rd_idle_ready", r0_req_ready, 2'b00);
        @(negedge clk);
        #1;
        chk("rd_req_valid", r0_valid, 1);
        chk("rd_req_addr", r0_addr, 28'h0000010);
        chk("rd_req_ready", r0_req_ready, 2'b01);
        chk("rd_req_busy", r0_busy, 1);
        @(negedge clk);
        cli_req_valid = 2'b00;
        #1;
        chk("rd_wait_valid", r0_valid, 0);
        chk("rd_wait_resp", r0_resp_valid, 2'b00);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = {16{8'hA5}};
        #1;
        chk("rd_resp_valid", r0_resp_valid, 2'b01);
        chk("rd_resp_data", r0_resp_data, {16{8'hA5}});
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("rd_done_busy", r0_busy, 0);
        chk("rd_done_resp", r0_resp_valid, 2'b00);

        // Simultaneous reads after reset: client 0 first (round-robin), client 1 first (priority)
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clk);
        cli_req_valid = 2'b11;
        cli_req_addr  = {28'h0000200, 28'h0000100};
        #1;
        chk("tie_idle_valid", r0_valid, 0);
        @(negedge clk);
        #1;
        chk("tie1_rr_addr", r0_addr, 28'h0000100);
        chk("tie1_rr_ready", r0_req_ready, 2'b01);
        chk("tie1_pr_addr", p1_addr, 28'h0000200);
        chk("tie1_pr_ready", p1_req_ready, 2'b10);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        #1;
        chk("tie1_rr_resp", r0_resp_valid, 2'b01);
        chk("tie1_pr_resp", p1_resp_valid, 2'b10);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("tie1_idle", r0_busy, 0);
        @(negedge clk);
        #1;
        chk("tie2_rr_ready", r0_req_ready, 2'b10);
        chk("tie2_rr_addr", r0_addr, 28'h0000200);
        chk("tie2_pr_ready", p1_req_ready, 2'b10);
        @(negedge clk);
        cli_req_valid  = 2'b00;
        mem_resp_valid = 1'b1;
        #1;
        chk("tie2_rr_resp", r0_resp_valid, 2'b10);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;

        // Client 1 write: address accepted two cycles ahead of the data
        cli_req_valid      = 2'b10;
        cli_req_rw         = 2'b10;
        cli_req_addr       = {28'h0000300, 28'h0};
        cli_req_data_valid = 2'b10;
        cli_req_data_bits  = {128'h0123456789ABCDEF_FEDCBA9876543210, 128'h0};
        cli_req_data_mask  = {16'h000F, 16'h0};
        #1;
        chk("wr_idle_busy", r0_busy, 0);
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        chk("wr_req_valid", r0_valid, 1);
        chk("wr_req_rw", r0_rw, 1);
        chk("wr_req_ready", r0_req_ready, 2'b10);
        chk("wr_dvalid", r0_data_valid, 1);
        chk("wr_mask", r0_mask, 16'h000F);
        chk("wr_dready_early", r0_data_ready, 2'b00);
        @(negedge clk);
        cli_req_valid = 2'b00;
        #1;
        chk("wr_valid_dropped", r0_valid, 0);
        chk("wr_ready_once", r0_req_ready, 2'b00);
        chk("wr_dvalid_hold", r0_data_valid, 1);
        chk("wr_still_busy", r0_busy, 1);
        @(negedge clk);
        mem_req_data_ready = 1'b1;
        #1;
        chk("wr_dready", r0_data_ready, 2'b10);
        chk("wr_dbits", r0_data_bits, 128'h0123456789ABCDEF_FEDCBA9876543210);
        @(negedge clk);
        cli_req_data_valid = 2'b00;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        #1;
        chk("wr_done_busy", r0_busy, 0);
        chk("wr_no_resp", r0_resp_valid, 2'b00);
        chk("wr_done_dvalid", r0_data_valid, 0);

        // Client 0 write with both readies in the same cycle
        @(negedge clk);
        cli_req_valid      = 2'b01;
        cli_req_rw         = 2'b01;
        cli_req_data_valid = 2'b01;
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b1;
        #1;
        chk("wr1_idle_ready", r0_req_ready, 2'b00);
        @(negedge clk);
        #1;
        chk("wr1_ready", r0_req_ready, 2'b01);
        chk("wr1_dready", r0_data_ready, 2'b01);
        @(negedge clk);
        cli_req_valid      = 2'b00;
        cli_req_data_valid = 2'b00;
        cli_req_rw         = 2'b00;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        #1;
        chk("wr1_idle", r0_busy, 0);

        // Spurious response while idle
        @(negedge clk);
        mem_resp_valid = 1'b1;
        #1;
        chk("spur_resp", r0_resp_valid, 2'b00);
        @(negedge clk);
        mem_resp_valid = 1'b0;

        // Client 0 withdraws in REQ, then client 1 is granted
        cli_req_valid = 2'b01;
        cli_req_addr  = {28'h0000400, 28'h0000050};
        @(negedge clk);
        cli_req_valid = 2'b10;
        #1;
        chk("drop_valid", r0_valid, 0);
        chk("drop_ready", r0_req_ready, 2'b00);
        chk("drop_busy", r0_busy, 1);
        @(negedge clk);
        #1;
        chk("drop_idle", r0_busy, 0);
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        chk("drop_c1_addr", r0_addr, 28'h0000400);
        chk("drop_c1_ready", r0_req_ready, 2'b10);

        // Reset in RESP aborts immediately
        @(negedge clk);
        cli_req_valid  = 2'b00;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        chk("abort_pre_resp", r0_resp_valid, 2'b10);
        reset = 1'b0;
        #1;
        chk("abort_resp", r0_resp_valid, 2'b00);
        chk("abort_busy", r0_busy, 0);
        chk("abort_ready", r0_req_ready, 2'b00);
        #1;
        reset          = 1'b1;
        mem_resp_valid = 1'b0;

        // Fresh read from client 1 after reset release
        @(negedge clk);
        cli_req_valid = 2'b10;
        cli_req_addr  = {28'h0000ABC, 28'h0};
        mem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("post_ready", r0_req_ready, 2'b10);
        chk("post_addr", r0_addr, 28'h0000ABC);
        @(negedge clk);
        cli_req_valid  = 2'b00;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {4{32'hDEADBEEF}};
        #1;
        chk("post_resp", r0_resp_valid, 2'b10);
        chk("post_data", r0_resp_data, {4{32'hDEADBEEF}});
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("post_idle", r0_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
